// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel millisecond timer: mode encodings and
// the channel-index width helper.
package timer_pkg;

  localparam logic [1:0] MODE_UP_ONESHOT    = 2'd0;
  localparam logic [1:0] MODE_UP_PERIODIC   = 2'd1;
  localparam logic [1:0] MODE_DOWN_ONESHOT  = 2'd2;
  localparam logic [1:0] MODE_DOWN_PERIODIC = 2'd3;

  // Channel-index width, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running clock prescaler: asserts tick for one cycle every CLKS_PER_TICK
// cycles, first in cycle CLKS_PER_TICK-1 after reset.
module timer_prescaler #(
  parameter int unsigned CLKS_PER_TICK = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned PW = $clog2(CLKS_PER_TICK);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = (cnt_q == PW'(CLKS_PER_TICK - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel programmable timer: NUM_CH independent up/down counters,
// each one-shot or periodic, advanced by a shared prescaler tick.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned CLKS_PER_TICK = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic [CNT_W-1:0]            cfg_limit,
  output logic                        cfg_err,
  input  logic [NUM_CH-1:0]           start,
  input  logic [NUM_CH-1:0]           stop,
  input  logic [NUM_CH-1:0]           flag_clr,
  output logic [NUM_CH-1:0]           running,
  output logic [NUM_CH-1:0]           expire,
  output logic [NUM_CH-1:0]           flag,
  input  logic [ch_width(NUM_CH)-1:0] rd_ch,
  output logic [CNT_W-1:0]            rd_value
);

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic              tick;
  logic              cfg_ch_ok;
  logic [NUM_CH-1:0] cfg_rej;
  logic              cfg_err_q;
  logic              cfg_err_d;
  logic [CNT_W-1:0]  cnt_arr [NUM_CH];

  timer_prescaler #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign cfg_ch_ok = (32'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             exp_q, exp_d;
    logic             flag_q, flag_d;
    logic             sel;
    logic             cfg_wr;
    logic             down;
    logic             periodic;
    logic             terminal;

    assign sel        = cfg_we && cfg_ch_ok && (cfg_ch == CH_W'(i));
    // Config may only change while the channel is idle and not being started.
    assign cfg_rej[i] = sel && (run_q || start[i]);
    assign cfg_wr     = sel && !run_q && !start[i];
    assign down       = mode_q[1];
    assign periodic   = mode_q[0];
    assign terminal   = down ? (cnt_q == '0) : (cnt_q == limit_q);

    always_comb begin
      mode_d  = mode_q;
      limit_d = limit_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      exp_d   = 1'b0;
      flag_d  = flag_q;
      if (cfg_wr) begin
        mode_d  = cfg_mode;
        limit_d = cfg_limit;
      end
      // Stop beats start; start swallows a coincident tick.
      if (stop[i]) begin
        run_d = 1'b0;
      end else if (start[i]) begin
        run_d = 1'b1;
        cnt_d = down ? limit_q : '0;
      end else if (tick && run_q) begin
        if (terminal) begin
          exp_d = 1'b1;
          if (periodic) begin
            cnt_d = down ? limit_q : '0;
          end else begin
            run_d = 1'b0;
          end
        end else begin
          cnt_d = down ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
        end
      end
      if (exp_d) begin
        flag_d = 1'b1;
      end else if (flag_clr[i]) begin
        flag_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        mode_q  <= MODE_UP_ONESHOT;
        limit_q <= '0;
        cnt_q   <= '0;
        run_q   <= 1'b0;
        exp_q   <= 1'b0;
        flag_q  <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        limit_q <= limit_d;
        cnt_q   <= cnt_d;
        run_q   <= run_d;
        exp_q   <= exp_d;
        flag_q  <= flag_d;
      end
    end

    assign running[i] = run_q;
    assign expire[i]  = exp_q;
    assign flag[i]    = flag_q;
    assign cnt_arr[i] = cnt_q;
  end

  always_comb begin
    cfg_err_d = cfg_we && (!cfg_ch_ok || (|cfg_rej));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err  = cfg_err_q;
  assign rd_value = (32'(rd_ch) < NUM_CH) ? cnt_arr[rd_ch] : '0;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: config vector table, expiry scoreboard and
// cycle-scheduled sequences for the multi-cycle corner cases.
module tb_multi_timer;
  import timer_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CPT    = 4;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             cfg_we    = 1'b0;
  logic [1:0]       cfg_ch    = '0;
  logic [1:0]       cfg_mode  = '0;
  logic [CNT_W-1:0] cfg_limit = '0;
  logic             cfg_err;
  logic [3:0]       start     = '0;
  logic [3:0]       stop      = '0;
  logic [3:0]       flag_clr  = '0;
  logic [3:0]       running;
  logic [3:0]       expire;
  logic [3:0]       flag;
  logic [1:0]       rd_ch     = '0;
  logic [CNT_W-1:0] rd_value;

  // Three-channel instance, so an unused channel index is representable.
  logic             cfg_we3 = 1'b0;
  logic [1:0]       cfg_ch3 = '0;
  logic             cfg_err3;
  logic [2:0]       running3;
  logic [2:0]       expire3;
  logic [2:0]       flag3;
  logic [CNT_W-1:0] rd_value3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int cyc;
    int ch;
  } exp_ev_t;
  exp_ev_t sb[$];

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [7:0] limit;
    logic [3:0] start;
    logic [3:0] stop;
    logic       exp_err;
    logic [3:0] exp_run;
  } cfg_vec_t;
  cfg_vec_t vecs[6];

  multi_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .CLKS_PER_TICK(CPT)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_limit(cfg_limit),
    .cfg_err  (cfg_err),
    .start    (start),
    .stop     (stop),
    .flag_clr (flag_clr),
    .running  (running),
    .expire   (expire),
    .flag     (flag),
    .rd_ch    (rd_ch),
    .rd_value (rd_value)
  );

  multi_timer #(
    .NUM_CH       (3),
    .CNT_W        (CNT_W),
    .CLKS_PER_TICK(CPT)
  ) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we3),
    .cfg_ch   (cfg_ch3),
    .cfg_mode (MODE_UP_PERIODIC),
    .cfg_limit(8'd5),
    .cfg_err  (cfg_err3),
    .start    (3'b000),
    .stop     (3'b000),
    .flag_clr (3'b000),
    .running  (running3),
    .expire   (expire3),
    .flag     (flag3),
    .rd_ch    (2'b00),
    .rd_value (rd_value3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance one cycle and compare expire against the scoreboard.
  task automatic next();
    logic [3:0] exp_v;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_v = '0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        exp_v[sb[k].ch] = 1'b1;
        sb.delete(k);
      end
    end
    check("expire", {28'd0, expire}, {28'd0, exp_v});
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) next();
  endtask

  task automatic rd(input int ch, input int exp_v, input string name);
    rd_ch = 2'(ch);
    #1;
    check(name, {24'd0, rd_value}, exp_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 2'd1, MODE_DOWN_ONESHOT,  8'd3, 4'b0000, 4'b0000, 1'b0, 4'b0001};
    vecs[1] = '{1'b1, 2'd0, MODE_UP_ONESHOT,    8'd7, 4'b0000, 4'b0000, 1'b1, 4'b0001};
    vecs[2] = '{1'b1, 2'd2, MODE_UP_ONESHOT,    8'd5, 4'b0000, 4'b0000, 1'b0, 4'b0001};
    vecs[3] = '{1'b1, 2'd3, MODE_DOWN_PERIODIC, 8'd1, 4'b0000, 4'b0000, 1'b0, 4'b0001};
    vecs[4] = '{1'b1, 2'd2, MODE_UP_PERIODIC,   8'd9, 4'b0100, 4'b0100, 1'b1, 4'b0001};
    vecs[5] = '{1'b0, 2'd0, MODE_UP_ONESHOT,    8'd1, 4'b0000, 4'b0000, 1'b0, 4'b0001};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    check("rst_running", {28'd0, running}, 0);
    check("rst_expire", {28'd0, expire}, 0);
    check("rst_flag", {28'd0, flag}, 0);
    check("rst_cfg_err", {31'd0, cfg_err}, 0);
    for (int c = 0; c < 4; c++) rd(c, 0, "rst_count");

    next();  // 1
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = MODE_UP_PERIODIC; cfg_limit = 8'd2;
    next();  // 2
    cfg_we = 1'b0;
    check("cfg_ok_ch0", {31'd0, cfg_err}, 0);
    next();  // 3: tick cycle, start consumes it
    start[0] = 1'b1;
    // Period limit+1 = 3 ticks; stopped at cycle 60 before the 5th expiry.
    for (int k = 1; k <= 4; k++) sb.push_back('{3 + CPT * 3 * k + 1, 0});
    next();  // 4
    start = '0;
    check("ch0_running", {28'd0, running}, 4'b0001);
    rd(0, 0, "ch0_cnt_start");

    goto_cyc(5);
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3;
    next();  // 6
    check("cfg_err_bad_ch", {31'd0, cfg_err3}, 1);
    cfg_ch3 = 2'd2;
    next();  // 7
    check("cfg_ok_3ch", {31'd0, cfg_err3}, 0);
    cfg_we3 = 1'b0;

    goto_cyc(8);  rd(0, 1, "ch0_cnt_t1");
    goto_cyc(12); rd(0, 2, "ch0_cnt_t2");
    goto_cyc(16); rd(0, 0, "ch0_cnt_reload");
    check("ch0_flag_set", {31'd0, flag[0]}, 1);

    goto_cyc(17);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = MODE_UP_ONESHOT; cfg_limit = 8'd7;
    next();  // 18
    cfg_we = 1'b0;
    check("cfg_err_running", {31'd0, cfg_err}, 1);
    next();  // 19
    check("cfg_err_one_cycle", {31'd0, cfg_err}, 0);

    goto_cyc(20);
    flag_clr[0] = 1'b1;
    next();  // 21
    flag_clr = '0;
    check("flag_clr", {31'd0, flag[0]}, 0);
    goto_cyc(27);  // tick that expires ch0 at 28
    flag_clr[0] = 1'b1;
    next();  // 28
    flag_clr = '0;
    check("flag_set_wins", {31'd0, flag[0]}, 1);

    goto_cyc(29);
    for (int r = 0; r < 6; r++) begin
      cfg_we = vecs[r].we; cfg_ch = vecs[r].ch; cfg_mode = vecs[r].mode;
      cfg_limit = vecs[r].limit; start = vecs[r].start; stop = vecs[r].stop;
      next();
      cfg_we = 1'b0; start = '0; stop = '0;
      check($sformatf("vec%0d_cfg_err", r), {31'd0, cfg_err}, {31'd0, vecs[r].exp_err});
      check($sformatf("vec%0d_running", r), {28'd0, running}, {28'd0, vecs[r].exp_run});
      next();
    end

    // cycle 41: one-shot down ch1, ticks at 43/47/51/55, expiry visible at 56
    start[1] = 1'b1;
    sb.push_back('{56, 1});
    next();  // 42
    start = '0;
    rd(1, 3, "ch1_cnt_load");
    check("ch1_running", {31'd0, running[1]}, 1);
    goto_cyc(44); rd(1, 2, "ch1_cnt_t1");
    goto_cyc(48); rd(1, 1, "ch1_cnt_t2");
    goto_cyc(52); rd(1, 0, "ch1_cnt_t3");
    goto_cyc(56); rd(1, 0, "ch1_cnt_expired");
    check("ch1_oneshot_idle", {31'd0, running[1]}, 0);
    check("ch1_flag", {31'd0, flag[1]}, 1);

    goto_cyc(60);
    stop[0] = 1'b1;
    next();  // 61
    stop = '0;
    check("ch0_stopped", {31'd0, running[0]}, 0);
    rd(0, 2, "ch0_cnt_hold");
    goto_cyc(64);
    rd(1, 0, "ch1_cnt_stays");
    check("ch1_still_idle", {31'd0, running[1]}, 0);
    goto_cyc(66); rd(0, 2, "ch0_cnt_hold2");

    goto_cyc(67);  // tick cycle
    start[2] = 1'b1;
    next();  // 68
    start = '0;
    check("ch2_running", {31'd0, running[2]}, 1);
    rd(2, 0, "ch2_tick_consumed");
    goto_cyc(72); rd(2, 1, "ch2_cnt_t1");
    goto_cyc(73);
    stop[2] = 1'b1;
    next();  // 74
    stop = '0;
    start = 4'b1111;
    next();  // 75
    start = '0;
    goto_cyc(78);
    check("all_running", {28'd0, running}, 4'b1111);
    check("flags_before_rst", {28'd0, flag}, 4'b0011);
    rd(1, 2, "ch1_cnt_pre_rst");
    rd(3, 0, "ch3_cnt_pre_rst");

    goto_cyc(79);  // ch3 terminal tick; reset must discard its expiry
    reset = 1'b1;
    next();  // 80
    check("midrst_running", {28'd0, running}, 0);
    check("midrst_flag", {28'd0, flag}, 0);
    check("midrst_cfg_err", {31'd0, cfg_err}, 0);
    for (int c = 0; c < 4; c++) rd(c, 0, "midrst_count");
    next();  // 81: prescaler at 0, next tick at 84
    reset = 1'b0;
    next();  // 82
    start[3] = 1'b1;  // reset config: up one-shot, limit 0
    sb.push_back('{85, 3});
    next();  // 83
    start = '0;
    check("ch3_running", {31'd0, running[3]}, 1);
    goto_cyc(85);
    check("ch3_limit0_done", {31'd0, running[3]}, 0);
    check("ch3_flag", {28'd0, flag}, 4'b1000);
    goto_cyc(88);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
